fetch_queue: RTL and testbench

Instruction fetch front end between the PC source and decode. Owns the fetch PC and drives the instruction cache's current and next PC. On each cache hit it captures the {pc, instruction} pair into a small FIFO, which decode drains with a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetch at the target.

---
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
//==============================================================================
// Module      : fetch_queue
// Description : Instruction fetch front end. Owns the fetch PC and drives the
//               cache's current/next PC. Cache hits are captured as
//               {pc, instr} pairs into a small FIFO that decode drains with a
//               valid/ready handshake. Redirects flush and restart fetch.
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_queue #(
   parameter int                     DEPTH    = 4,
   parameter logic [`ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [`ADDR_WIDTH-1:0]     pc_current,
   output logic [`ADDR_WIDTH-1:0]     pc_next,
   input  logic                       ic_valid,
   input  logic [`DATA_WIDTH-1:0]     ic_data,
   input  logic                       redirect_valid,
   input  logic [`ADDR_WIDTH-1:0]     redirect_pc,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [`ADDR_WIDTH-1:0]     deq_pc,
   output logic [`DATA_WIDTH-1:0]     deq_instr,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0]     c_DEPTH_CNT = c_CNT_W'(DEPTH);
   localparam logic [`ADDR_WIDTH-1:0] c_PC_STEP   = `ADDR_WIDTH'(4);

   logic [`ADDR_WIDTH-1:0] r_fetch_pc;
   logic [c_PTR_W-1:0]     r_rd_ptr;
   logic [c_PTR_W-1:0]     r_wr_ptr;
   logic [c_CNT_W-1:0]     r_count;
   logic [`ADDR_WIDTH-1:0] r_mem_pc    [DEPTH];
   logic [`DATA_WIDTH-1:0] r_mem_instr [DEPTH];

   logic                   w_full;
   logic                   w_enq;
   logic                   w_pop;
   logic                   w_deq_valid;
   logic [`ADDR_WIDTH-1:0] w_pc_next;

   // A full queue refuses the hit even if decode pops this cycle; the cache
   // simply re-presents the same hit next cycle because fetch_pc holds.
   assign w_full      = (r_count == c_DEPTH_CNT);
   assign w_enq       = ic_valid & ~w_full & ~redirect_valid;
   assign w_deq_valid = (r_count != '0) & ~redirect_valid;
   assign w_pop       = w_deq_valid & deq_ready;

   // Next fetch address; deliberately independent of deq_ready
   always_comb begin
      w_pc_next = r_fetch_pc;
      if (rst)
         w_pc_next = RESET_PC;
      else if (redirect_valid)
         w_pc_next = redirect_pc;
      else if (w_enq)
         w_pc_next = r_fetch_pc + c_PC_STEP;
   end

   // Fetch PC follows pc_next every edge (reset value already folded in)
   always_ff @(posedge clk) begin
      r_fetch_pc <= w_pc_next;
   end

   // Queue pointers and occupancy; redirect flushes everything
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq)
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_enq && !rst) begin
         r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
         r_mem_instr[r_wr_ptr] <= ic_data;
      end
   end

   assign pc_current = r_fetch_pc;
   assign pc_next    = w_pc_next;
   assign deq_valid  = w_deq_valid;
   assign deq_pc     = r_mem_pc[r_rd_ptr];
   assign deq_instr  = r_mem_instr[r_rd_ptr];
   assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
//==============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A queue-based model of
//               the fetch front end is checked against the DUT every cycle,
//               plus directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_fetch_queue;

   localparam int                     c_DEPTH    = 4;
   localparam logic [`ADDR_WIDTH-1:0] c_RESET_PC = 32'h100;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [`ADDR_WIDTH-1:0] pc_current;
   logic [`ADDR_WIDTH-1:0] pc_next;
   logic                   ic_valid;
   logic [`DATA_WIDTH-1:0] ic_data;
   logic                   redirect_valid;
   logic [`ADDR_WIDTH-1:0] redirect_pc;
   logic                   deq_valid;
   logic                   deq_ready;
   logic [`ADDR_WIDTH-1:0] deq_pc;
   logic [`DATA_WIDTH-1:0] deq_instr;
   logic [$clog2(c_DEPTH):0] count;

   int checks = 0;
   int errors = 0;
   bit model_on = 1'b0;

   fetch_queue #(.DEPTH(c_DEPTH), .RESET_PC(c_RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .pc_current(pc_current), .pc_next(pc_next),
      .ic_valid(ic_valid), .ic_data(ic_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_pc(deq_pc), .deq_instr(deq_instr), .count(count)
   );

   always #5 clk = ~clk;

   // Cache contents: a fixed scramble of the address
   function automatic logic [`DATA_WIDTH-1:0] instr_of(input logic [`ADDR_WIDTH-1:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   assign ic_data = instr_of(pc_current);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a queue of {pc, instr} and the fetch address
   // ------------------------------------------------------------------
   logic [`ADDR_WIDTH-1:0] m_pc_q    [$];
   logic [`DATA_WIDTH-1:0] m_instr_q [$];
   logic [`ADDR_WIDTH-1:0] m_fetch;

   initial begin
      bit                     exp_valid;
      bit                     hit_ok;
      logic [`ADDR_WIDTH-1:0] exp_next;
      forever begin
         @(negedge clk);
         hit_ok    = ic_valid && (m_pc_q.size() < c_DEPTH) && !redirect_valid;
         exp_valid = (m_pc_q.size() != 0) && !redirect_valid;
         if (rst)                 exp_next = c_RESET_PC;
         else if (redirect_valid) exp_next = redirect_pc;
         else if (hit_ok)         exp_next = m_fetch + 32'd4;
         else                     exp_next = m_fetch;
         if (model_on) begin
            chk("pc_current", 64'(pc_current), 64'(m_fetch));
            chk("pc_next",    64'(pc_next),    64'(exp_next));
            chk("count",      64'(count),      64'(m_pc_q.size()));
            chk("deq_valid",  64'(deq_valid),  64'(exp_valid));
            if (exp_valid) begin
               chk("deq_pc",    64'(deq_pc),    64'(m_pc_q[0]));
               chk("deq_instr", 64'(deq_instr), 64'(m_instr_q[0]));
            end
         end
         @(posedge clk);
         if (rst || redirect_valid) begin
            m_pc_q.delete();
            m_instr_q.delete();
            m_fetch = rst ? c_RESET_PC : redirect_pc;
         end else begin
            if (exp_valid && deq_ready) begin
               void'(m_pc_q.pop_front());
               void'(m_instr_q.pop_front());
            end
            if (hit_ok) begin
               m_pc_q.push_back(m_fetch);
               m_instr_q.push_back(instr_of(m_fetch));
               m_fetch = m_fetch + 32'd4;
            end
         end
         if (rst) model_on = 1'b1;
      end
   end

   // Advance to just after the next rising edge; inputs change here
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input bit r, input bit iv, input bit rv,
                        input logic [`ADDR_WIDTH-1:0] rpc, input bit dr);
      rst = r; ic_valid = iv; redirect_valid = rv; redirect_pc = rpc; deq_ready = dr;
   endtask

   initial begin
      drive(1, 0, 0, '0, 0);
      cyc(3);
      chk("reset pc_current", 64'(pc_current), 64'h100);
      chk("reset count",      64'(count),      64'd0);
      chk("reset deq_valid",  64'(deq_valid),  64'd0);

      // Streaming: one instruction per cycle, count steady at 1
      drive(0, 1, 0, '0, 1);
      #1;
      chk("stream first pc_next", 64'(pc_next), 64'h104);
      cyc(6);
      chk("stream pc_current", 64'(pc_current), 64'h118);
      chk("stream count",      64'(count),      64'd1);
      chk("stream deq_pc",     64'(deq_pc),     64'h114);

      // Fill to full with decode stalled, then drain in order
      drive(0, 1, 1, 32'h100, 0);
      cyc(1);
      drive(0, 1, 0, '0, 0);
      cyc(7);
      chk("full count",      64'(count),      64'd4);
      chk("full pc_current", 64'(pc_current), 64'h110);
      chk("full deq_pc",     64'(deq_pc),     64'h100);
      chk("full deq_instr",  64'(deq_instr),  64'(32'h5B5A_C3C3));
      drive(0, 0, 0, '0, 1);
      cyc(4);
      chk("drained count", 64'(count), 64'd0);

      // Misses hold the fetch PC while the queue drains
      drive(0, 1, 1, 32'h1F8, 0);
      cyc(1);
      drive(0, 1, 0, '0, 0);
      cyc(2);
      drive(0, 0, 0, '0, 1);
      cyc(5);
      chk("miss pc_current", 64'(pc_current), 64'h200);
      chk("miss count",      64'(count),      64'd0);
      drive(0, 1, 0, '0, 0);
      cyc(1);
      chk("miss-then-hit count",  64'(count),     64'd1);
      chk("miss-then-hit deq_pc", 64'(deq_pc),    64'h200);
      chk("miss-then-hit instr",  64'(deq_instr), 64'(32'h585A_C3C3));

      // Redirect with 3 entries queued
      cyc(2);
      drive(0, 1, 1, 32'h400, 1);
      #1;
      chk("redirect deq_valid", 64'(deq_valid), 64'd0);
      chk("redirect pc_next",   64'(pc_next),   64'h400);
      cyc(1);
      chk("post-redirect count", 64'(count),      64'd0);
      chk("post-redirect pc",    64'(pc_current), 64'h400);
      drive(0, 1, 0, '0, 1);
      cyc(1);
      chk("redirect target deq_valid", 64'(deq_valid), 64'd1);
      chk("redirect target deq_pc",    64'(deq_pc),    64'h400);

      // Address wrap at the top of the space
      drive(0, 1, 1, 32'hFFFF_FFFC, 0);
      cyc(1);
      drive(0, 1, 0, '0, 0);
      #1;
      chk("wrap pc_next", 64'(pc_next), 64'h0);
      cyc(1);
      chk("wrap pc_current", 64'(pc_current), 64'h0);
      cyc(1);
      drive(0, 0, 0, '0, 1);
      #1;
      chk("wrap head pc", 64'(deq_pc), 64'hFFFF_FFFC);
      cyc(1);
      chk("wrap second pc", 64'(deq_pc), 64'h0);

      // Reset beats a simultaneous redirect and discards queued entries
      drive(0, 1, 0, '0, 0);
      cyc(1);
      chk("pre-reset count", 64'(count), 64'd2);
      drive(1, 1, 1, 32'h800, 1);
      cyc(1);
      drive(0, 0, 0, '0, 0);
      chk("post-reset count", 64'(count),      64'd0);
      chk("post-reset pc",    64'(pc_current), 64'h100);
      cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
